// File: rtl/mmio_bus_ctrl_if.sv
// Core-side data bus: store strobe, byte address, store data and combinational load data.
interface mmio_bus_ctrl_if;
  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, dataaddr, writedata, input readdata);
  modport slave  (input memwrite, dataaddr, writedata, output readdata);
endinterface

// File: rtl/mmio_bus_ctrl.sv
// Data-bus decoder for the single-cycle core: dmem/smem routing plus keyboard FIFO,
// millisecond timer, LED and sound-period registers. Loads are combinational, stores commit at i_clk.
module mmio_bus_ctrl #(
  parameter int KEY_DEPTH    = 8,
  parameter int TICKS_PER_MS = 100000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  mmio_bus_ctrl_if.slave      bus,
  output logic                o_dmem_we,
  input  logic [31:0]         i_dmem_rd,
  output logic                o_smem_we,
  input  logic [31:0]         i_smem_rd,
  input  logic                i_key_valid,
  input  logic [7:0]          i_key_code,
  output logic [15:0]         o_led,
  output logic [31:0]         o_sound_period
);
  localparam int AW = $clog2(KEY_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(TICKS_PER_MS);

  logic [31:0]   w_addr;
  logic          w_sel_dmem, w_sel_smem, w_sel_kdata, w_sel_kstat;
  logic          w_sel_timer, w_sel_led, w_sel_sound;
  logic          w_full, w_nonempty, w_push, w_pop, w_drop, w_ovf_clr, w_tick;
  logic [7:0]    w_cnt8;
  logic          w_unused;

  logic [7:0]    r_mem [KEY_DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [PW-1:0] r_presc;
  logic [31:0]   r_timer;
  logic [15:0]   r_led;
  logic [31:0]   r_sound;

  // Byte offset is irrelevant: all registers are word-wide.
  assign w_addr      = {bus.dataaddr[31:2], 2'b00};
  assign w_unused    = ^bus.dataaddr[1:0];
  assign w_sel_dmem  = (w_addr[31:16] == 16'h1001);
  assign w_sel_smem  = (w_addr[31:16] == 16'h1002);
  assign w_sel_kdata = (w_addr == 32'h1003_0000);
  assign w_sel_kstat = (w_addr == 32'h1003_0004);
  assign w_sel_timer = (w_addr == 32'h1003_0008);
  assign w_sel_led   = (w_addr == 32'h1003_0010);
  assign w_sel_sound = (w_addr == 32'h1003_0014);

  assign o_dmem_we = bus.memwrite & w_sel_dmem;
  assign o_smem_we = bus.memwrite & w_sel_smem;

  assign w_full     = (r_count == CW'(KEY_DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_cnt8     = 8'(r_count);
  assign w_pop      = bus.memwrite & w_sel_kdata & w_nonempty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push     = i_key_valid & (~w_full | w_pop);
  assign w_drop     = i_key_valid & w_full & ~w_pop;
  assign w_ovf_clr  = bus.memwrite & w_sel_kstat & bus.writedata[2];
  assign w_tick     = (r_presc == PW'(TICKS_PER_MS - 1));

  always_comb begin
    bus.readdata = '0;
    if (w_sel_dmem)       bus.readdata = i_dmem_rd;
    else if (w_sel_smem)  bus.readdata = i_smem_rd;
    else if (w_sel_kdata) bus.readdata = w_nonempty ? {24'h0, r_mem[r_rd_ptr]} : 32'h0;
    else if (w_sel_kstat) bus.readdata = {16'h0, w_cnt8, 5'h0, r_ovf, w_full, w_nonempty};
    else if (w_sel_timer) bus.readdata = r_timer;
    else if (w_sel_led)   bus.readdata = {16'h0, r_led};
    else if (w_sel_sound) bus.readdata = r_sound;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_key_code;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // Set dominates clear so an overflow is never lost.
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_presc <= '0;
      r_timer <= '0;
    end else if (bus.memwrite && w_sel_timer) begin
      r_presc <= '0;
      r_timer <= bus.writedata;
    end else if (w_tick) begin
      r_presc <= '0;
      r_timer <= r_timer + 32'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_led   <= '0;
      r_sound <= '0;
    end else begin
      if (bus.memwrite && w_sel_led)   r_led   <= bus.writedata[15:0];
      if (bus.memwrite && w_sel_sound) r_sound <= bus.writedata;
    end
  end

  assign o_led          = r_led;
  assign o_sound_period = r_sound;
endmodule
